// File: rtl/rr_demux_router_if.sv
// Handshake bundle for rr_demux_router: one input stream in, NUM_CH registered channels out.
// The master side is the source/consumer environment, the slave side is the router.
interface rr_demux_router_if #(
  parameter int DATA_W = 1,
  parameter int NUM_CH = 4,
  parameter int SEL_W  = 2
);
  logic [DATA_W-1:0]        in_data;
  logic                     in_valid;
  logic                     in_ready;
  logic [NUM_CH*DATA_W-1:0] out_data;
  logic [NUM_CH-1:0]        out_valid;
  logic [NUM_CH-1:0]        out_ready;
  logic [SEL_W-1:0]         cur_sel;

  modport master (
    output in_data, in_valid, out_ready,
    input  in_ready, out_data, out_valid, cur_sel
  );

  modport slave (
    input  in_data, in_valid, out_ready,
    output in_ready, out_data, out_valid, cur_sel
  );
endinterface

// File: rtl/rr_demux_router.sv
// Registered round-robin 1-to-NUM_CH demux stage with a one-entry register per channel.
// Build option: define DEMUX_INVERT_EN to store the bitwise NOT of every accepted word.
module rr_demux_router #(
  parameter int DATA_W = 1,
  parameter int NUM_CH = 4,
  parameter int SEL_W  = 2
) (
  input  logic            clk,
  input  logic            rst,
  rr_demux_router_if.slave bus
);

  logic [SEL_W-1:0]         cur_sel_q, cur_sel_d;
  logic [NUM_CH-1:0]        out_valid_q, out_valid_d;
  logic [NUM_CH*DATA_W-1:0] out_data_q, out_data_d;
  logic                     in_ready_s;
  logic                     acc_s;

  function automatic logic [DATA_W-1:0] store_word(input logic [DATA_W-1:0] w);
`ifdef DEMUX_INVERT_EN
    return ~w;
`else
    return w;
`endif
  endfunction

  // Next-state: readiness of the pointed channel, load/drain per channel, pointer advance.
  always_comb begin
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    cur_sel_d   = cur_sel_q;
    in_ready_s  = 1'b0;

    // The pointer never skips a full channel, so only the selected channel gates acceptance.
    for (int i = 0; i < NUM_CH; i++) begin
      in_ready_s = in_ready_s |
                   ((SEL_W'(i) == cur_sel_q) & (~out_valid_q[i] | bus.out_ready[i]));
    end
    acc_s = bus.in_valid & in_ready_s;

    for (int i = 0; i < NUM_CH; i++) begin
      if (acc_s && (SEL_W'(i) == cur_sel_q)) begin
        out_data_d[i*DATA_W +: DATA_W] = store_word(bus.in_data);
        out_valid_d[i]                 = 1'b1;
      end else if (out_valid_q[i] && bus.out_ready[i]) begin
        out_valid_d[i] = 1'b0;
      end else begin
        out_valid_d[i] = out_valid_q[i];
      end
    end

    if (acc_s) begin
      cur_sel_d = (cur_sel_q == SEL_W'(NUM_CH - 1)) ? {SEL_W{1'b0}} : cur_sel_q + SEL_W'(1);
    end else begin
      cur_sel_d = cur_sel_q;
    end
  end

  // State registers with asynchronous reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cur_sel_q   <= {SEL_W{1'b0}};
      out_valid_q <= {NUM_CH{1'b0}};
      out_data_q  <= {(NUM_CH*DATA_W){1'b0}};
    end else begin
      cur_sel_q   <= cur_sel_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
    end
  end

  assign bus.in_ready  = in_ready_s;
  assign bus.out_data  = out_data_q;
  assign bus.out_valid = out_valid_q;
  assign bus.cur_sel   = cur_sel_q;

endmodule

// File: tb/tb_rr_demux_router.sv
// Directed self-checking bench for rr_demux_router: 4-channel, 3-channel and 1-bit instances.
module tb_rr_demux_router;
  logic clk;
  logic rst;
  int   checks;
  int   failures;

`ifdef DEMUX_INVERT_EN
  localparam bit INV = 1'b1;
`else
  localparam bit INV = 1'b0;
`endif

  rr_demux_router_if #(.DATA_W(8), .NUM_CH(4), .SEL_W(2)) bus4 ();
  rr_demux_router_if #(.DATA_W(8), .NUM_CH(3), .SEL_W(2)) bus3 ();
  rr_demux_router_if #(.DATA_W(1), .NUM_CH(4), .SEL_W(2)) bus1 ();

  rr_demux_router #(.DATA_W(8), .NUM_CH(4), .SEL_W(2)) u4 (.clk(clk), .rst(rst), .bus(bus4));
  rr_demux_router #(.DATA_W(8), .NUM_CH(3), .SEL_W(2)) u3 (.clk(clk), .rst(rst), .bus(bus3));
  rr_demux_router #(.DATA_W(1), .NUM_CH(4), .SEL_W(2)) u1 (.clk(clk), .rst(rst), .bus(bus1));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [7:0] exp8(input logic [7:0] w);
    return INV ? ~w : w;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    tick();
  endtask

  task automatic send4(input logic [7:0] w);
    bus4.in_valid = 1'b1;
    bus4.in_data  = w;
    tick();
    bus4.in_valid = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    bus4.out_ready = 4'b0000;
    send4(8'h01);
    send4(8'h02);
    send4(8'h03);
    bus4.out_ready = 4'b0001;
    tick();
    bus4.out_ready = 4'b0000;
    checks++;
    if (bus4.out_valid !== 4'b0110 || bus4.cur_sel !== 2'd3) begin
      failures++;
      $display("FAIL pre_reset valid=%b sel=%0d exp valid=0110 sel=3", bus4.out_valid, bus4.cur_sel);
    end
    rst = 1'b1;
    #1;
    checks++;
    if (bus4.out_valid !== 4'b0000 || bus4.cur_sel !== 2'd0 || bus4.in_ready !== 1'b1) begin
      failures++;
      $display("FAIL async_reset valid=%b sel=%0d rdy=%b exp 0000/0/1",
               bus4.out_valid, bus4.cur_sel, bus4.in_ready);
    end
    tick();
    checks++;
    if (bus4.out_valid !== 4'b0000 || bus4.cur_sel !== 2'd0 || bus4.in_ready !== 1'b1 ||
        bus4.out_data !== 32'h0) begin
      failures++;
      $display("FAIL reset_hold valid=%b sel=%0d rdy=%b data=%h exp 0000/0/1/0",
               bus4.out_valid, bus4.cur_sel, bus4.in_ready, bus4.out_data);
    end
    rst = 1'b0;
    tick();
  endtask

  task automatic test_rotation();
    logic [7:0] w;
    do_reset();
    bus4.out_ready = 4'b1111;
    for (int k = 0; k < 5; k++) begin
      w = 8'hA0 + 8'(k);
      bus4.in_valid = 1'b1;
      bus4.in_data  = w;
      #1;
      checks++;
      if (bus4.in_ready !== 1'b1 || bus4.cur_sel !== 2'(k % 4)) begin
        failures++;
        $display("FAIL rot_pre k=%0d rdy=%b sel=%0d exp 1/%0d", k, bus4.in_ready, bus4.cur_sel, k % 4);
      end
      tick();
      checks++;
      if (bus4.out_data[(k % 4)*8 +: 8] !== exp8(w) || bus4.out_valid[k % 4] !== 1'b1) begin
        failures++;
        $display("FAIL rot_load k=%0d data=%h vld=%b exp %h/1",
                 k, bus4.out_data[(k % 4)*8 +: 8], bus4.out_valid[k % 4], exp8(w));
      end
    end
    bus4.in_valid = 1'b0;
    checks++;
    if (bus4.out_data !== {exp8(8'hA3), exp8(8'hA2), exp8(8'hA1), exp8(8'hA4)} ||
        bus4.cur_sel !== 2'd1 || bus4.out_valid !== 4'b0001) begin
      failures++;
      $display("FAIL rot_final data=%h sel=%0d valid=%b", bus4.out_data, bus4.cur_sel, bus4.out_valid);
    end
    bus4.out_ready = 4'b0000;
  endtask

  task automatic test_full_stall();
    do_reset();
    bus4.out_ready = 4'b0000;
    for (int k = 0; k < 4; k++) send4(8'hB0 + 8'(k));
    bus4.in_valid = 1'b1;
    bus4.in_data  = 8'hB4;
    #1;
    checks++;
    if (bus4.out_valid !== 4'b1111 || bus4.in_ready !== 1'b0 || bus4.cur_sel !== 2'd0) begin
      failures++;
      $display("FAIL stall_full valid=%b rdy=%b sel=%0d exp 1111/0/0",
               bus4.out_valid, bus4.in_ready, bus4.cur_sel);
    end
    tick();
    tick();
    checks++;
    if (bus4.out_data[7:0] !== exp8(8'hB0) || bus4.cur_sel !== 2'd0) begin
      failures++;
      $display("FAIL stall_hold ch0=%h sel=%0d exp %h/0", bus4.out_data[7:0], bus4.cur_sel, exp8(8'hB0));
    end
    bus4.out_ready = 4'b0001;
    #1;
    checks++;
    if (bus4.in_ready !== 1'b1) begin
      failures++;
      $display("FAIL stall_release rdy=%b exp 1", bus4.in_ready);
    end
    tick();
    bus4.in_valid  = 1'b0;
    bus4.out_ready = 4'b0000;
    checks++;
    if (bus4.out_data[7:0] !== exp8(8'hB4) || bus4.out_valid !== 4'b1111 || bus4.cur_sel !== 2'd1) begin
      failures++;
      $display("FAIL stall_land ch0=%h valid=%b sel=%0d exp %h/1111/1",
               bus4.out_data[7:0], bus4.out_valid, bus4.cur_sel, exp8(8'hB4));
    end
  endtask

  task automatic test_drain_load();
    do_reset();
    bus4.out_ready = 4'b0000;
    send4(8'h11);
    send4(8'h22);
    send4(8'h33);
    send4(8'h44);
    bus4.out_ready = 4'b0001;
    send4(8'h5C);
    bus4.out_ready = 4'b0000;
    checks++;
    if (bus4.out_valid !== 4'b1111 || bus4.out_data[7:0] !== exp8(8'h5C) ||
        bus4.out_data[15:8] !== exp8(8'h22) || bus4.cur_sel !== 2'd1) begin
      failures++;
      $display("FAIL drain_load valid=%b data=%h sel=%0d", bus4.out_valid, bus4.out_data, bus4.cur_sel);
    end
    bus4.out_ready = 4'b0010;
    tick();
    bus4.out_ready = 4'b0000;
    checks++;
    if (bus4.out_valid !== 4'b1101 || bus4.out_data[15:8] !== exp8(8'h22) || bus4.cur_sel !== 2'd1) begin
      failures++;
      $display("FAIL drain_only valid=%b ch1=%h sel=%0d exp 1101/%h/1",
               bus4.out_valid, bus4.out_data[15:8], bus4.cur_sel, exp8(8'h22));
    end
    bus4.out_ready = 4'b0010;
    tick();
    bus4.out_ready = 4'b0000;
    checks++;
    if (bus4.out_valid !== 4'b1101) begin
      failures++;
      $display("FAIL ready_on_empty valid=%b exp 1101", bus4.out_valid);
    end
  endtask

  task automatic test_wrap3();
    logic [7:0] w;
    do_reset();
    bus3.out_ready = 3'b111;
    for (int k = 0; k < 7; k++) begin
      w = 8'hC0 + 8'(k);
      bus3.in_valid = 1'b1;
      bus3.in_data  = w;
      #1;
      checks++;
      if (bus3.cur_sel !== 2'(k % 3) || bus3.in_ready !== 1'b1) begin
        failures++;
        $display("FAIL wrap3_sel k=%0d sel=%0d rdy=%b exp %0d/1", k, bus3.cur_sel, bus3.in_ready, k % 3);
      end
      tick();
      checks++;
      if (bus3.out_data[(k % 3)*8 +: 8] !== exp8(w)) begin
        failures++;
        $display("FAIL wrap3_data k=%0d got=%h exp=%h", k, bus3.out_data[(k % 3)*8 +: 8], exp8(w));
      end
    end
    bus3.in_valid = 1'b0;
    checks++;
    if (bus3.cur_sel !== 2'd1) begin
      failures++;
      $display("FAIL wrap3_final sel=%0d exp 1", bus3.cur_sel);
    end
    bus3.out_ready = 3'b000;
  endtask

  task automatic test_invert();
    do_reset();
    bus1.out_ready = 4'b0000;
    bus1.in_valid  = 1'b1;
    bus1.in_data   = 1'b1;
    tick();
    bus1.in_data   = 1'b0;
    tick();
    bus1.in_valid  = 1'b0;
    checks++;
    if (bus1.out_data[0] !== (INV ? 1'b0 : 1'b1) || bus1.out_data[1] !== (INV ? 1'b1 : 1'b0) ||
        bus1.out_valid !== 4'b0011) begin
      failures++;
      $display("FAIL inv_1bit data=%b valid=%b inv=%0d", bus1.out_data, bus1.out_valid, INV);
    end
    bus4.out_ready = 4'b0000;
    send4(8'h0F);
    checks++;
    if (bus4.out_data[7:0] !== (INV ? 8'hF0 : 8'h0F)) begin
      failures++;
      $display("FAIL inv_8bit got=%h inv=%0d", bus4.out_data[7:0], INV);
    end
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    rst      = 1'b1;
    bus4.in_data = 8'h00; bus4.in_valid = 1'b0; bus4.out_ready = 4'b0000;
    bus3.in_data = 8'h00; bus3.in_valid = 1'b0; bus3.out_ready = 3'b000;
    bus1.in_data = 1'b0;  bus1.in_valid = 1'b0; bus1.out_ready = 4'b0000;
    test_reset();
    test_rotation();
    test_full_stall();
    test_drain_load();
    test_wrap3();
    test_invert();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
